// File: rtl/mc_request_scheduler.sv
// mc_request_scheduler: in-order memory request queue feeding an open-page
// DDR4 command sequencer (ACT / RD / WR / PRE) with 16-bank open-row tracking
// and a fixed minimum spacing between issued commands.
module mc_request_scheduler #(
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 33,
    parameter int T_GAP         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    input  logic [1:0]               op_code,
    input  logic [ADDRESS_WIDTH-1:0] op_addr,
    output logic                     op_accept,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     q_empty,
    output logic                     cmd_valid,
    output logic [2:0]               cmd,
    output logic [1:0]               cmd_bg,
    output logic [1:0]               cmd_bank,
    output logic [14:0]              cmd_row,
    output logic [9:0]               cmd_col,
    input  logic                     cmd_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(T_GAP) + 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(T_GAP - 1);

    // Parser op encoding (parsed_op_t)
    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] OP_IFETCH = 2'd3;

    localparam logic [2:0] CMD_NONE = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_PRE  = 3'd2;
    localparam logic [2:0] CMD_RD   = 3'd3;
    localparam logic [2:0] CMD_WR   = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_PRE    = 3'd2;
    localparam logic [2:0] ST_ACT    = 3'd3;
    localparam logic [2:0] ST_ACCESS = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;

    // Only the decoded address fields are stored; addr[3:0] is don't-care.
    typedef struct packed {
        logic        wr;
        logic [14:0] row;
        logic [9:0]  col;
        logic [1:0]  bank;
        logic [1:0]  bg;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_reg;
    entry_t          new_entry;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic            overflow_reg;
    logic [2:0]      state_reg, state_next;
    logic [2:0]      follow_reg, follow_next;
    logic [CW-1:0]   gap_cnt_reg, gap_cnt_next;
    logic            head_load;
    logic            op_real, enq, pop, cmd_active, cmd_hs;
    logic            bank_open_reg [16];
    logic [14:0]     bank_row_reg [16];
    logic [3:0]      head_idx;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^op_addr[3:0];

    assign new_entry = '{wr:   (op_code == OP_WRITE),
                         row:  op_addr[32:18],
                         col:  op_addr[17:8],
                         bank: op_addr[7:6],
                         bg:   op_addr[5:4]};

    assign q_full    = (count_reg == (PW+1)'(DEPTH));
    assign q_empty   = (count_reg == '0);
    assign q_count   = count_reg;
    assign op_accept = !q_full;
    assign overflow  = overflow_reg;

    assign op_real    = op_valid && (op_code != OP_NOP);
    assign enq        = op_real && !q_full;
    assign cmd_active = (state_reg == ST_PRE) || (state_reg == ST_ACT) || (state_reg == ST_ACCESS);
    assign cmd_hs     = cmd_active && cmd_ready;
    assign pop        = (state_reg == ST_ACCESS) && cmd_ready;
    assign head_idx   = {head_reg.bg, head_reg.bank};

    // Request storage: plain write port, no reset, so it maps to RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_reg] <= new_entry;
        end
    end

    // Registered read of the head entry, taken as the FSM leaves IDLE.
    always_ff @(posedge clk) begin
        if (head_load) begin
            head_reg <= mem[rd_ptr_reg];
        end
    end

    // Queue pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (enq && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!enq && pop) begin
                count_reg <= count_reg - 1'b1;
            end
            if (op_real && q_full) overflow_reg <= 1'b1;
        end
    end

    // Per-bank open/row tracking, updated on ACT and PRE handshakes.
    for (genvar gi = 0; gi < 16; gi++) begin : g_bank
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                bank_open_reg[gi] <= 1'b0;
            end else if (cmd_ready && (head_idx == 4'(gi))) begin
                if (state_reg == ST_ACT) begin
                    bank_open_reg[gi] <= 1'b1;
                    bank_row_reg[gi]  <= head_reg.row;
                end else if (state_reg == ST_PRE) begin
                    bank_open_reg[gi] <= 1'b0;
                end
            end
        end
    end

    // Command sequencer next-state logic.
    always_comb begin
        state_next   = state_reg;
        follow_next  = follow_reg;
        gap_cnt_next = gap_cnt_reg;
        head_load    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_next = ST_DECODE;
                    head_load  = 1'b1;
                end
            end
            ST_DECODE: begin
                if (!bank_open_reg[head_idx]) begin
                    state_next = ST_ACT;
                end else if (bank_row_reg[head_idx] == head_reg.row) begin
                    state_next = ST_ACCESS;
                end else begin
                    state_next = ST_PRE;
                end
            end
            ST_PRE, ST_ACT, ST_ACCESS: begin
                if (cmd_ready) begin
                    if (state_reg == ST_PRE) begin
                        follow_next = ST_ACT;
                    end else if (state_reg == ST_ACT) begin
                        follow_next = ST_ACCESS;
                    end else begin
                        follow_next = ST_IDLE;
                    end
                    gap_cnt_next = GAP_LOAD;
                    state_next   = (T_GAP == 1) ? follow_next : ST_WAIT;
                end
            end
            ST_WAIT: begin
                gap_cnt_next = gap_cnt_reg - 1'b1;
                if (gap_cnt_reg == CW'(1)) begin
                    state_next = follow_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            follow_reg  <= ST_IDLE;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            follow_reg  <= follow_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // Command outputs come straight from the state and the stable head entry.
    always_comb begin
        cmd = CMD_NONE;
        case (state_reg)
            ST_PRE:    cmd = CMD_PRE;
            ST_ACT:    cmd = CMD_ACT;
            ST_ACCESS: cmd = head_reg.wr ? CMD_WR : CMD_RD;
            default:   cmd = CMD_NONE;
        endcase
    end

    assign cmd_valid = cmd_active;
    assign cmd_bg    = cmd_active ? head_reg.bg   : '0;
    assign cmd_bank  = cmd_active ? head_reg.bank : '0;
    assign cmd_row   = cmd_active ? head_reg.row  : '0;
    assign cmd_col   = cmd_active ? head_reg.col  : '0;

endmodule

// File: tb/tb_mc_request_scheduler.sv
// Bench for mc_request_scheduler: directed stimulus, a timing-level model of
// the queue/command stream checked every cycle, plus literal spot checks.
module tb_mc_request_scheduler;

    localparam int DEPTH = 16;
    localparam int AW    = 33;
    localparam int T_GAP = 4;

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] OP_IFETCH = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid;
    logic [1:0]    op_code;
    logic [AW-1:0] op_addr;
    logic          op_accept, overflow, q_full, q_empty;
    logic [4:0]    q_count;
    logic          cmd_valid;
    logic [2:0]    cmd;
    logic [1:0]    cmd_bg, cmd_bank;
    logic [14:0]   cmd_row;
    logic [9:0]    cmd_col;
    logic          cmd_ready;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    mc_request_scheduler #(.DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .T_GAP(T_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code), .op_addr(op_addr),
        .op_accept(op_accept), .overflow(overflow), .q_count(q_count), .q_full(q_full),
        .q_empty(q_empty), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ready(cmd_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    typedef struct {
        int        enq;
        bit        wr;
        bit [1:0]  bg, bank;
        bit [14:0] row;
        bit [9:0]  col;
    } req_t;

    typedef struct {
        bit [2:0]  c;
        bit [1:0]  bg, bank;
        bit [14:0] row;
        bit [9:0]  col;
    } mcmd_t;

    req_t      m_q[$];
    mcmd_t     m_plan[$];
    bit        m_open[16];
    bit [14:0] m_row[16];
    int        m_next;
    int        m_last_h;
    bit        m_ovf;

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Commands a request needs given the bank table when it reaches the head.
    task automatic build_plan();
        req_t  r;
        mcmd_t c;
        int    idx;
        r = m_q[0];
        idx = {r.bg, r.bank};
        c.bg = r.bg; c.bank = r.bank; c.row = r.row; c.col = r.col;
        if (m_open[idx] && m_row[idx] != r.row) begin
            c.c = 3'd2; m_plan.push_back(c);
        end
        if (!m_open[idx] || m_row[idx] != r.row) begin
            c.c = 3'd1; m_plan.push_back(c);
        end
        c.c = r.wr ? 3'd4 : 3'd3;
        m_plan.push_back(c);
        // Two cycles (IDLE look, DECODE) after both the queue holds the
        // request and the previous access's gap has elapsed.
        m_next = imax(m_last_h + T_GAP, r.enq + 1) + 2;
    endtask

    // One compare per cycle, then advance the model through the clock edge.
    always @(negedge clk) begin
        logic [41:0] got, want;
        bit          e_valid;
        mcmd_t       e;
        int          pre_size;
        req_t        r;
        if (!rst_n) begin
            m_q.delete();
            m_plan.delete();
            for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
            m_last_h = -1000;
            m_next   = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_plan.size() == 0 && m_q.size() > 0) build_plan();
            e_valid = (m_plan.size() > 0) && (cyc >= m_next);
            e = '{c: 3'd0, bg: 2'd0, bank: 2'd0, row: 15'd0, col: 10'd0};
            if (e_valid) e = m_plan[0];
            want = {e_valid, e.c, e.bg, e.bank, e.row, e.col, 5'(m_q.size()),
                    (m_q.size() == DEPTH), (m_q.size() == 0), (m_q.size() != DEPTH), m_ovf};
            got  = {cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, q_count,
                    q_full, q_empty, op_accept, overflow};
            n_total++;
            if (got === want) n_pass++;
            else $display("FAIL outputs cyc=%0d got %h required %h", cyc, got, want);

            pre_size = m_q.size();
            if (e_valid && cmd_ready) begin
                if (e.c == 3'd1) begin
                    m_open[{e.bg, e.bank}] = 1'b1;
                    m_row[{e.bg, e.bank}]  = e.row;
                end else if (e.c == 3'd2) begin
                    m_open[{e.bg, e.bank}] = 1'b0;
                end
                if (e.c == 3'd3 || e.c == 3'd4) begin
                    void'(m_q.pop_front());
                    m_last_h = cyc;
                end else begin
                    m_next = cyc + T_GAP;
                end
                void'(m_plan.pop_front());
            end
            if (op_valid && op_code != OP_NOP) begin
                if (pre_size < DEPTH) begin
                    r.enq = cyc; r.wr = (op_code == OP_WRITE);
                    r.row = op_addr[32:18]; r.col = op_addr[17:8];
                    r.bank = op_addr[7:6]; r.bg = op_addr[5:4];
                    m_q.push_back(r);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got %0h required %0h", name, cyc, act, exp);
    endtask

    task automatic offer(logic [1:0] code, logic [AW-1:0] addr);
        op_valid = 1'b1;
        op_code  = code;
        op_addr  = addr;
    endtask

    task automatic idle_op();
        op_valid = 1'b0;
        op_code  = OP_NOP;
        op_addr  = '0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_ready = 1'b1;
        idle_op();

        // Reset values
        tick(2);
        rst_n = 1'b1;
        $display("txn reset: released at cyc %0d", cyc);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_op_accept", 32'(op_accept), 1);
        chk("rst_q_empty", 32'(q_empty), 1);
        chk("rst_q_full", 32'(q_full), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // Closed bank, row hit, row conflict, table update
        n = cyc;
        offer(OP_READ, 33'h0_0004_0150);
        $display("txn enqueue READ 0x000040150 at cyc %0d", cyc);
        tick();
        offer(OP_IFETCH, 33'h0_0004_0250);
        $display("txn enqueue IFETCH 0x000040250 at cyc %0d", cyc);
        tick();
        offer(OP_WRITE, 33'h0_0008_0150);
        $display("txn enqueue WRITE 0x000080150 at cyc %0d", cyc);
        tick();
        offer(OP_READ, 33'h0_0008_0150);
        $display("txn enqueue READ 0x000080150 at cyc %0d", cyc);
        chk("act1_cmd", 32'(cmd), 1);
        chk("act1_bg", 32'(cmd_bg), 1);
        chk("act1_bank", 32'(cmd_bank), 1);
        chk("act1_row", 32'(cmd_row), 1);
        tick();
        offer(OP_NOP, 33'h1_FFFF_FFFF);
        tick();
        idle_op();
        tick(2);
        chk("rd1_cmd", 32'(cmd), 3);
        chk("rd1_col", 32'(cmd_col), 1);
        chk("rd1_q_count", 32'(q_count), 4);
        tick();
        chk("after_rd1_q_count", 32'(q_count), 3);
        tick(4);
        chk("hit_gap_idle", 32'(cmd_valid), 0);
        tick();
        chk("hit_rd_cmd", 32'(cmd), 3);
        chk("hit_rd_col", 32'(cmd_col), 2);
        tick(6);
        chk("conf_pre_cmd", 32'(cmd), 2);
        tick(4);
        chk("conf_act_cmd", 32'(cmd), 1);
        chk("conf_act_row", 32'(cmd_row), 2);
        tick(4);
        chk("conf_wr_cmd", 32'(cmd), 4);
        tick(6);
        chk("row2_hit_cmd", 32'(cmd), 3);
        chk("row2_hit_row", 32'(cmd_row), 2);
        $display("txn sequence done at cyc %0d (start %0d)", cyc, n);
        tick(8);
        chk("drain_q_empty", 32'(q_empty), 1);

        // Overflow with the sequencer stalled on ACT
        cmd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            offer(OP_READ, 33'h0_0014_0000 + 33'(i * 256));
            if (i == 16) begin
                chk("full_q_full", 32'(q_full), 1);
                chk("full_op_accept", 32'(op_accept), 0);
            end
            $display("txn offer READ #%0d at cyc %0d accept=%0b", i, cyc, op_accept);
            tick();
        end
        idle_op();
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_q_count", 32'(q_count), 16);
        chk("ovf_cmd", 32'(cmd), 1);
        chk("ovf_row", 32'(cmd_row), 5);
        tick(3);
        chk("stall_row", 32'(cmd_row), 5);
        chk("stall_col", 32'(cmd_col), 0);

        // Reset while ACT pending
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("txn reset during stalled ACT at cyc %0d", cyc);
        chk("rst2_cmd_valid", 32'(cmd_valid), 0);
        chk("rst2_q_empty", 32'(q_empty), 1);
        chk("rst2_overflow", 32'(overflow), 0);

        // Reset while WR pending
        cmd_ready = 1'b1;
        offer(OP_WRITE, 33'h0_0008_0150);
        $display("txn enqueue WRITE 0x000080150 at cyc %0d", cyc);
        tick();
        idle_op();
        tick(2);
        chk("wr_pre_act", 32'(cmd), 1);
        tick(4);
        cmd_ready = 1'b0;
        chk("wr_pending", 32'(cmd), 4);
        tick(3);
        chk("wr_held", 32'(cmd), 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("txn reset during stalled WR at cyc %0d", cyc);
        chk("rst3_cmd_valid", 32'(cmd_valid), 0);
        chk("rst3_q_empty", 32'(q_empty), 1);
        cmd_ready = 1'b1;
        offer(OP_READ, 33'h0_0008_0150);
        $display("txn enqueue READ 0x000080150 at cyc %0d", cyc);
        tick();
        idle_op();
        tick(2);
        chk("post_rst_act", 32'(cmd), 1);
        chk("post_rst_act_row", 32'(cmd_row), 2);
        tick(4);
        chk("post_rst_rd", 32'(cmd), 3);
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
